sprite_ram_writer: RTL and testbench
====================================

// Module: sprite_ram_writer
// PURPOSE
//  Write side of the sprite memories that the sprite controllers read during active video.
//  Accepts a load command (base address, word count), then streams pixel words from a
//  valid/ready source into the sprite RAM write port.
//  Writes occur only in vertical blanking, so sprites never tear while being drawn.
//  Sits between the host/loader stream and port A of each sprite dual-port RAM.
// PARAMETERS
//  ADDR_W    16   sprite RAM address width; write address wraps modulo 2**ADDR_W
//  DATA_W    8    sprite pixel word width
//  V_ACTIVE  480  first blanking line; blanking window is line >= V_ACTIVE
// PORTS
//  clk        in   1          system/pixel clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  line       in   `CORDW     current raster line from the video timing generator
//  cmd_valid  in   1          load command valid
//  cmd_ready  out  1          load command accepted when cmd_valid && cmd_ready
//  cmd_base   in   ADDR_W     first RAM address of the load
//  cmd_len    in   ADDR_W     number of words to write (0 = empty load)
//  abort      in   1          synchronous abort of the current load
//  s_valid    in   1          pixel stream word valid
//  s_ready    out  1          pixel stream word accepted when s_valid && s_ready
//  s_data     in   DATA_W     pixel stream word
//  wr_en      out  1          RAM write enable
//  wr_addr    out  ADDR_W     RAM write address
//  wr_data    out  DATA_W     RAM write data
//  busy       out  1          high from command accept until DONE or abort
//  done       out  1          one-cycle pulse when the last word has been written
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State IDLE; all outputs 0; internal addr, remaining and in_blank cleared.
//  Blanking flag
//   - in_blank is registered: in_blank <= (line >= V_ACTIVE), so it lags line by 1 cycle.
//  FSM states: IDLE, WAIT_BLANK, WRITE, DONE
//   - IDLE: cmd_ready = !abort. On accept, addr <= cmd_base, remaining <= cmd_len, busy <= 1.
//     Next state is DONE if cmd_len == 0, else WAIT_BLANK.
//   - WAIT_BLANK: s_ready = 0. Goes to WRITE when in_blank == 1.
//   - WRITE: s_ready = in_blank. On each handshake: addr <= addr+1 (wrapping), remaining -= 1.
//     On the handshake where remaining == 1, next state is DONE.
//     If in_blank falls with remaining != 0, return to WAIT_BLANK; addr and remaining hold,
//     and the load resumes in the next blanking period.
//   - DONE: done = 1 for exactly 1 cycle, busy <= 0, then IDLE.
//   - cmd_ready = 0 in every state except IDLE; commands are never queued.
//  Write port
//   - Registered. wr_en, wr_addr, wr_data appear on the cycle after the handshake,
//     with wr_addr equal to the pre-increment addr.
//   - wr_en is high only on those cycles. No bubbles are inserted when s_valid stays high.
//  Abort
//   - Any state except IDLE: next state is IDLE, busy <= 0, done is not pulsed, s_ready = 0
//     in the abort cycle.
//   - A write whose handshake happened in the previous cycle still completes on wr_*.
//   - Abort in IDLE blocks cmd accept in that cycle (abort wins over cmd_valid).
//  Arithmetic
//   - cmd_base + cmd_len > 2**ADDR_W wraps to address 0 and continues; no error is raised.
// STRUCTURE
//  Shared define.v holds: `CORDW, `V_ACTIVE_LINES (default for V_ACTIVE) and the FSM state
//  encodings (2-bit), so the sprite controllers and this writer agree on the raster limits.
//  The FSM, counters and write register live in one module. There is no sub-module; the
//  blanking compare is a single registered comparator kept inline.
// TESTING
//  1. Reset mid-WRITE -> next cycle wr_en=0, busy=0, cmd_ready=1, state IDLE.
//  2. line=500, base=0x0100, len=4, s_valid held 1 with data A,B,C,D ->
//     wr_addr 0x0100..0x0103 on 4 consecutive cycles; done pulses once, 1 cycle after
//     the last wr_en.
//  3. Command accepted at line=100 -> s_ready=0 and no wr_en until the cycle after
//     line reaches 480; then all words are written.
//  4. len=10, blanking ends after 6 words -> writes stop, busy stays 1; next blanking
//     resumes at base+6, and exactly 10 total writes occur.
//  5. base=0xFFFE, len=4 -> wr_addr sequence FFFE, FFFF, 0000, 0001.
//  6. len=0 -> done 2 cycles after accept, no wr_en. Abort in WRITE -> IDLE, no done,
//     at most 1 trailing wr_en. cmd_valid+abort in IDLE -> not accepted.

Source files
------------

// File: rtl/sprite_ram_writer_pkg.sv
// ---------------------------------------------------------------------------
// sprite_ram_writer_pkg
//   Shared raster limits and writer FSM encoding. The sprite controllers and
//   the writer import the same values so they agree on the raster limits.
//   CORDW          : width of raster line/column coordinates
//   V_ACTIVE_LINES : first vertical blanking line (default for V_ACTIVE)
//   wr_state_t     : 2-bit writer FSM state encoding
// ---------------------------------------------------------------------------
package sprite_ram_writer_pkg;

    localparam int CORDW          = 10;
    localparam int V_ACTIVE_LINES = 480;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        WRITE      = 2'd2,
        DONE       = 2'd3
    } wr_state_t;

endpackage

// File: rtl/sprite_ram_writer.sv
// ---------------------------------------------------------------------------
// sprite_ram_writer
//   Write side of the sprite memories. A load command (base, length) is
//   accepted, then pixel words from a valid/ready stream are written into
//   sprite RAM port A, but only while the raster is in vertical blanking so
//   the sprite controllers never read a half-updated sprite.
//
// Ports
//   clk       : system/pixel clock, rising edge
//   rst_n     : asynchronous active-low reset
//   line      : current raster line from the video timing generator
//   cmd_valid : load command valid
//   cmd_ready : load command accepted when cmd_valid && cmd_ready
//   cmd_base  : first RAM address of the load
//   cmd_len   : number of words to write (0 = empty load)
//   abort     : synchronous abort of the current load
//   s_valid   : pixel stream word valid
//   s_ready   : pixel stream word accepted when s_valid && s_ready
//   s_data    : pixel stream word
//   wr_en     : RAM write enable (registered)
//   wr_addr   : RAM write address (registered)
//   wr_data   : RAM write data (registered)
//   busy      : high from command accept until done or abort
//   done      : one-cycle pulse after the last word has been written
// ---------------------------------------------------------------------------
module sprite_ram_writer
    import sprite_ram_writer_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int V_ACTIVE = V_ACTIVE_LINES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CORDW-1:0]  line,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [CORDW-1:0]  V_ACTIVE_C = CORDW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    wr_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic              in_blank;
    logic              cmd_fire;
    logic              s_fire;

    // The handshake signals must react to abort in the same cycle, so they
    // are decoded combinationally from the registered state. cmd_ready is
    // also held low while reset is asserted so every output reads 0 then.
    assign cmd_ready = rst_n && (state == IDLE) && !abort;
    assign s_ready   = (state == WRITE) && in_blank && !abort;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign s_fire    = s_valid && s_ready;

    // Registered blanking flag; it trails the line input by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_blank <= 1'b0;
        end else begin
            in_blank <= (line >= V_ACTIVE_C);
        end
    end

    // Load sequencer. Abort overrides everything outside IDLE. When blanking
    // ends mid-load, addr and remaining simply hold in WAIT_BLANK so the load
    // picks up where it stopped in the next blanking period. The address
    // counter wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_fire) begin
                            addr      <= cmd_base;
                            remaining <= cmd_len;
                            busy      <= 1'b1;
                            state     <= (cmd_len == '0) ? DONE : WAIT_BLANK;
                        end
                    end
                    WAIT_BLANK: begin
                        if (in_blank) begin
                            state <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (s_fire) begin
                            addr      <= addr + ONE;
                            remaining <= remaining - ONE;
                            if (remaining == ONE) begin
                                state <= DONE;
                            end
                        end else if (!in_blank) begin
                            state <= WAIT_BLANK;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Registered RAM write port: one write per accepted word, using the
    // address before it was incremented. A handshake taken just before an
    // abort still lands here on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= s_fire;
            if (s_fire) begin
                wr_addr <= addr;
                wr_data <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_sprite_ram_writer
//   Self-checking bench for sprite_ram_writer. Every accepted stream word is
//   expected to appear on the write port one cycle later at base + (number
//   of words accepted so far in this load), modulo 2**ADDR_W. Stream
//   handshakes are only legal while the previous cycle's line was in
//   blanking and no abort is present.
// ---------------------------------------------------------------------------
module tb_sprite_ram_writer;
    import sprite_ram_writer_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int V_ACT  = 480;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CORDW-1:0]  line;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_len;
    logic              abort;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    sprite_ram_writer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .V_ACTIVE (V_ACT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line      (line),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [ADDR_W-1:0] load_base   = '0;
    int                accepted    = 0;
    bit                accept_seen = 1'b0;
    int                accept_cyc  = 0;
    bit                model_blank = 1'b0;
    bit                blank_next  = 1'b0;
    bit                pend_valid  = 1'b0;
    logic [ADDR_W-1:0] pend_addr   = '0;
    logic [DATA_W-1:0] pend_data   = '0;

    // Per-scenario statistics
    int                wr_count     = 0;
    int                done_count   = 0;
    int                first_wr_cyc = -1;
    int                last_wr_cyc  = -1;
    int                done_cyc     = -1;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit valid);
        s_valid = valid;
        s_data  = DATA_W'($urandom);
    endtask

    task automatic clear_stats();
        wr_count     = 0;
        done_count   = 0;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
        done_cyc     = -1;
    endtask

    // One clock cycle: observe handshakes at the falling edge, then check the
    // registered outputs just after the rising edge.
    task automatic step();
        cyc++;
        @(negedge clk);
        if (!model_blank || abort || !rst_n)
            check_output("s_ready_gate", s_ready, 1'b0);
        pend_valid = 1'b0;
        if (s_valid && s_ready) begin
            pend_valid = 1'b1;
            pend_addr  = load_base + ADDR_W'(accepted);
            pend_data  = s_data;
            accepted++;
        end
        if (cmd_valid && cmd_ready) begin
            load_base   = cmd_base;
            accepted    = 0;
            accept_seen = 1'b1;
            accept_cyc  = cyc;
        end
        blank_next = (int'(line) >= V_ACT);
        @(posedge clk);
        #1;
        model_blank = rst_n && blank_next;
        check_output("wr_en", wr_en, pend_valid);
        if (pend_valid) begin
            check_output("wr_addr", wr_addr, pend_addr);
            check_output("wr_data", wr_data, pend_data);
            wr_count++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc + 1;
            last_wr_cyc  = cyc + 1;
            last_wr_addr = wr_addr;
        end
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc + 1;
        end
    endtask

    task automatic issue_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        cmd_valid   = 1'b1;
        cmd_base    = base;
        cmd_len     = len;
        accept_seen = 1'b0;
        step();
        cmd_valid = 1'b0;
        check_output("cmd_accept", accept_seen, 1'b1);
    endtask

    task automatic run_until_done(input int budget, input bit rand_valid);
        int n = 0;
        int start_done = done_count;
        while (done_count == start_done && n < budget) begin
            apply_stimulus(rand_valid ? 1'($urandom_range(0, 1)) : 1'b1);
            step();
            n++;
        end
        check_output("done_in_budget", done_count != start_done, 1'b1);
        s_valid = 1'b0;
    endtask

    task automatic feed_until(input int target, input int budget);
        int n = 0;
        while (accepted < target && n < budget) begin
            apply_stimulus(1'b1);
            step();
            n++;
        end
        check_output("feed_reached", accepted >= target, 1'b1);
    endtask

    initial begin
        int line_cyc;
        int a_cyc;
        logic [ADDR_W-1:0] rbase;
        logic [ADDR_W-1:0] rlen;

        rst_n     = 1'b0;
        line      = '0;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        abort     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_wr_en", wr_en, 1'b0);
        check_output("rst_wr_addr", wr_addr, '0);
        check_output("rst_wr_data", wr_data, '0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_cmd_ready", cmd_ready, 1'b0);
        check_output("rst_s_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check_output("idle_cmd_ready", cmd_ready, 1'b1);
        step();

        // Burst in blanking with s_valid held high
        $display("[TB] burst in blanking");
        line = CORDW'(500);
        step();
        clear_stats();
        issue_cmd(16'h0100, 16'd4);
        run_until_done(20, 1'b0);
        check_output("burst_count", wr_count, 4);
        check_output("burst_no_bubble", last_wr_cyc - first_wr_cyc, 3);
        check_output("burst_first_lat", first_wr_cyc - accept_cyc, 3);
        check_output("burst_done_cyc", done_cyc, last_wr_cyc + 1);
        check_output("burst_last_addr", last_wr_addr, 16'h0103);
        check_output("burst_busy_low", busy, 1'b0);
        apply_stimulus(1'b0);
        step();
        check_output("burst_done_once", done_count, 1);

        // Command accepted during active video
        $display("[TB] wait for blanking");
        line = CORDW'(100);
        repeat (2) step();
        clear_stats();
        issue_cmd(16'($urandom), 16'd5);
        repeat (6) begin
            apply_stimulus(1'b1);
            step();
        end
        check_output("active_no_write", wr_count, 0);
        check_output("active_busy", busy, 1'b1);
        line     = CORDW'(V_ACT);
        line_cyc = cyc + 1;
        run_until_done(60, 1'b1);
        check_output("blank_count", wr_count, 5);
        check_output("blank_first_ok", first_wr_cyc >= line_cyc + 3, 1'b1);

        // Load split across two blanking periods
        $display("[TB] split load");
        line = CORDW'(500);
        step();
        clear_stats();
        issue_cmd(16'($urandom), 16'd10);
        feed_until(5, 30);
        line = CORDW'(100);
        apply_stimulus(1'b1);
        step();
        repeat (5) begin
            apply_stimulus(1'b1);
            step();
        end
        check_output("split_pause_count", wr_count, 6);
        check_output("split_pause_busy", busy, 1'b1);
        line = CORDW'(500);
        run_until_done(40, 1'b0);
        check_output("split_total", wr_count, 10);
        check_output("split_done_once", done_count, 1);

        // Address wrap
        $display("[TB] address wrap");
        step();
        clear_stats();
        issue_cmd(16'hFFFE, 16'd4);
        run_until_done(40, 1'b1);
        check_output("wrap_count", wr_count, 4);
        check_output("wrap_last_addr", last_wr_addr, 16'h0001);

        // Empty load
        $display("[TB] empty load");
        clear_stats();
        issue_cmd(16'($urandom), 16'd0);
        a_cyc = accept_cyc;
        run_until_done(10, 1'b1);
        check_output("empty_done_cyc", done_cyc, a_cyc + 2);
        check_output("empty_no_write", wr_count, 0);

        // Abort during WRITE
        $display("[TB] abort in write");
        clear_stats();
        issue_cmd(16'($urandom), 16'd8);
        feed_until(3, 20);
        abort = 1'b1;
        apply_stimulus(1'b1);
        step();
        abort = 1'b0;
        repeat (4) begin
            apply_stimulus(1'b1);
            step();
        end
        s_valid = 1'b0;
        check_output("abort_no_done", done_count, 0);
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_trailing", wr_count, accepted);
        check_output("abort_cmd_ready", cmd_ready, 1'b1);

        // Abort wins over cmd_valid in IDLE
        $display("[TB] abort in idle");
        cmd_valid   = 1'b1;
        cmd_base    = 16'h1234;
        cmd_len     = 16'd3;
        abort       = 1'b1;
        accept_seen = 1'b0;
        step();
        check_output("idle_abort_no_accept", accept_seen, 1'b0);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        step();
        check_output("idle_abort_busy", busy, 1'b0);

        // Randomized loads
        $display("[TB] random loads");
        repeat (4) begin
            rbase = 16'($urandom);
            rlen  = 16'($urandom_range(1, 12));
            clear_stats();
            issue_cmd(rbase, rlen);
            run_until_done(200, 1'b1);
            check_output("rand_count", wr_count, rlen);
            check_output("rand_done_once", done_count, 1);
        end

        // Reset in the middle of a load
        $display("[TB] reset mid write");
        clear_stats();
        issue_cmd(16'($urandom), 16'd20);
        feed_until(3, 20);
        rst_n = 1'b0;
        #1;
        check_output("midrst_wr_en", wr_en, 1'b0);
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_done", done, 1'b0);
        apply_stimulus(1'b1);
        step();
        rst_n = 1'b1;
        #1;
        check_output("midrst_cmd_ready", cmd_ready, 1'b1);
        check_output("midrst_busy_after", busy, 1'b0);
        step();
        s_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
